wb_port_arbiter: RTL and testbench

- Shares the GPR write ports between the variable-latency result sources: FPU units (fadd/fsub/fmul/fdiv/fsqrt/ftoi/itof, upper and lower lanes) and the load-return path.
- Each source presents a valid/rt/tdata result and holds it until it is granted.
- The block picks up to NPORT results per cycle with a round-robin priority pointer, rejects same-register collisions within a cycle, and drives registered write-port signals into the GPR.
- It sits between the FPU/memory result buses and the register-file write logic in the writeback stage.

---
 rtl/wb_arb_pkg.sv | 34 +++
 rtl/rr_pick.sv | 46 ++++
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
package wb_arb_pkg;

  localparam int WB_NREQ   = 8;
  localparam int WB_NPORT  = 2;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Requester slots on the result bus. fsub shares the adder lane,
  // fsqrt shares the divider lane, ftoi/itof return through the multiplier lane.
  typedef enum logic [2:0] {
    U_FADD = 3'd0,
    L_FADD = 3'd1,
    U_FMUL = 3'd2,
    L_FMUL = 3'd3,
    U_FDIV = 3'd4,
    L_FDIV = 3'd5,
    LOAD_U = 3'd6,
    LOAD_L = 3'd7
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] rt;
    logic [WB_DATA_W-1:0] tdata;
  } wb_req_t;

  typedef struct packed {
    logic                 en;
    logic [WB_ADDR_W-1:0] rt;
    logic [WB_DATA_W-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: one-hot first set bit of i_mask at or after i_ptr,
// scanning upward and wrapping modulo N (N need not be a power of two).
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [N-1:0] w_rot;

  // Index of the requester 'off' positions after 'base', modulo N.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Rotate the mask so that position 0 is the current pointer.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++) begin
      w_rot[j] = i_mask[wrap_add(i_ptr, j)];
    end
  end

  // Priority-encode the lowest rotated bit and map it back to a requester index.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_found = 1'b1;
        o_idx   = wrap_add(i_ptr, j);
      end
    end
    if (o_found) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants up to NPORT results per cycle in round-robin
// order, skipping same-destination collisions, and registers the GPR write ports.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int  NREQ   = WB_NREQ,
  parameter int  NPORT  = WB_NPORT,
  parameter int  DATA_W = WB_DATA_W,
  parameter int  ADDR_W = WB_ADDR_W,
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_interlock,
  input  logic [NREQ-1:0]               i_req_valid,
  input  logic [NREQ-1:0][ADDR_W-1:0]   i_req_rt,
  input  logic [NREQ-1:0][DATA_W-1:0]   i_req_tdata,
  output logic [NREQ-1:0]               o_req_ready,
  output logic [NPORT-1:0]              o_wr_en,
  output logic [NPORT-1:0][ADDR_W-1:0]  o_wr_rt,
  output logic [NPORT-1:0][DATA_W-1:0]  o_wr_data,
  output logic [IDX_W-1:0]              o_rr_ptr,
  output logic                          o_conflict_stall
);

  logic [IDX_W-1:0]             r_rr_ptr;
  logic [NPORT-1:0]             r_wr_en;
  logic [NPORT-1:0][ADDR_W-1:0] r_wr_rt;
  logic [NPORT-1:0][DATA_W-1:0] r_wr_data;
  logic                         r_conflict_stall;

  logic [NPORT-1:0]             w_found;
  logic [NPORT-1:0][IDX_W-1:0]  w_idx;
  logic [NPORT-1:0][NREQ-1:0]   w_grant;
  logic [NPORT-1:0][ADDR_W-1:0] w_sel_rt;
  logic [NPORT-1:0][DATA_W-1:0] w_sel_data;
  logic [NREQ-1:0]              w_left;
  logic [NREQ-1:0]              w_blocked;
  logic [NREQ-1:0]              w_grant_any;
  logic                         w_go;
  logic [IDX_W-1:0]             w_last_idx;
  logic [IDX_W-1:0]             w_ptr_next;
  logic                         w_conflict;

  // One pick stage per write port. Each stage sees the requests not yet granted
  // and not colliding with a destination already claimed by an earlier stage.
  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_stage
      logic [NREQ-1:0]  w_avail_in;
      logic [NREQ-1:0]  w_blk_in;
      logic [NREQ-1:0]  w_mask;
      logic [NREQ-1:0]  w_pick;
      logic [NREQ-1:0]  w_avail_out;
      logic [NREQ-1:0]  w_blk_out;
      logic [IDX_W-1:0] w_pidx;
      logic             w_hit;

      if (gi == 0) begin : g_head
        assign w_avail_in = i_req_valid;
        assign w_blk_in   = '0;
      end else begin : g_tail
        assign w_avail_in = g_stage[gi-1].w_avail_out;
        assign w_blk_in   = g_stage[gi-1].w_blk_out;
      end

      assign w_mask = w_avail_in & ~w_blk_in;

      rr_pick #(
        .N  (NREQ),
        .IW (IDX_W)
      ) u_pick (
        .i_mask  (w_mask),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pidx),
        .o_found (w_hit)
      );

      assign w_avail_out = w_avail_in & ~w_pick;

      // Add every requester targeting this stage's destination to the blocked set.
      always_comb begin
        w_blk_out = w_blk_in;
        for (int j = 0; j < NREQ; j++) begin
          if (w_hit && (i_req_rt[j] == i_req_rt[w_pidx])) w_blk_out[j] = 1'b1;
        end
      end

      assign w_found[gi]    = w_hit;
      assign w_idx[gi]      = w_pidx;
      assign w_grant[gi]    = w_pick;
      assign w_sel_rt[gi]   = i_req_rt[w_pidx];
      assign w_sel_data[gi] = i_req_tdata[w_pidx];
    end
  endgenerate

  assign w_left    = g_stage[NPORT-1].w_avail_out;
  assign w_blocked = g_stage[NPORT-1].w_blk_out;
  assign w_go      = ~i_interlock & ~i_rst;

  // Merge the per-port grants into the requester handshake.
  always_comb begin
    w_grant_any = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_grant_any = w_grant_any | w_grant[k];
    end
    o_req_ready = w_go ? w_grant_any : '0;
  end

  // Pointer moves to just past the last requester granted this cycle.
  always_comb begin
    w_last_idx = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (w_found[k]) w_last_idx = w_idx[k];
    end
    w_ptr_next = (w_last_idx == IDX_W'(NREQ - 1)) ? '0 : w_last_idx + 1'b1;
  end

  // A port went unused while some valid request was held back by a collision.
  assign w_conflict = ~w_found[NPORT-1] & (|(w_left & w_blocked));

  // Register the write ports, pointer and collision flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_en          <= '0;
      r_wr_rt          <= '0;
      r_wr_data        <= '0;
      r_rr_ptr         <= '0;
      r_conflict_stall <= 1'b0;
    end else if (i_interlock) begin
      r_wr_en          <= '0;
      r_conflict_stall <= 1'b0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        r_wr_en[k]   <= w_found[k] && (w_sel_rt[k] != '0);
        r_wr_rt[k]   <= w_found[k] ? w_sel_rt[k] : '0;
        r_wr_data[k] <= w_found[k] ? w_sel_data[k] : '0;
      end
      if (w_found[0]) r_rr_ptr <= w_ptr_next;
      r_conflict_stall <= w_conflict;
    end
  end

  assign o_wr_en          = r_wr_en;
  assign o_wr_rt          = r_wr_rt;
  assign o_wr_data        = r_wr_data;
  assign o_rr_ptr         = r_rr_ptr;
  assign o_conflict_stall = r_conflict_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter using a scoreboard of expected port writes.
module tb_wb_port_arbiter;

  logic             clk;
  logic             rst;
  logic             interlock;
  logic [7:0]       tb_valid;
  logic [7:0][4:0]  tb_rt;
  logic [7:0][31:0] tb_data;
  logic [7:0]       ready;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_rt;
  logic [1:0][31:0] wr_data;
  logic [2:0]       rr_ptr;
  logic             conflict;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  slot;
    logic [4:0]  rt [2];
    logic [31:0] data [2];
    logic [2:0]  ptr;
    logic        conflict;
  } exp_t;

  exp_t sb[$];

  // Bench's own view of the registered state
  int          m_ptr;
  logic [1:0]  m_slot;
  logic [4:0]  m_rt [2];
  logic [31:0] m_data [2];

  wb_port_arbiter dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_interlock      (interlock),
    .i_req_valid      (tb_valid),
    .i_req_rt         (tb_rt),
    .i_req_tdata      (tb_data),
    .o_req_ready      (ready),
    .o_wr_en          (wr_en),
    .o_wr_rt          (wr_rt),
    .o_wr_data        (wr_data),
    .o_rr_ptr         (rr_ptr),
    .o_conflict_stall (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr   = 0;
    m_slot  = '0;
    m_rt[0] = '0; m_rt[1] = '0;
    m_data[0] = '0; m_data[1] = '0;
  endtask

  // Pop the next expected write-port state and compare it to the DUT.
  task automatic cmp_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(e.en));
    chk({tag, ".rr_ptr"}, 32'(rr_ptr), 32'(e.ptr));
    chk({tag, ".conflict"}, 32'(conflict), 32'(e.conflict));
    for (int k = 0; k < 2; k++) begin
      if (e.slot[k]) begin
        chk($sformatf("%s.wr_rt%0d", tag, k), 32'(wr_rt[k]), 32'(e.rt[k]));
        chk($sformatf("%s.wr_data%0d", tag, k), wr_data[k], e.data[k]);
      end
    end
  endtask

  // One arbitration cycle: predict grants by scanning from the pointer, check
  // req_ready, push the expected port state, clock, then compare and consume.
  task automatic run_cycle(input string tag);
    exp_t       e;
    int         ng;
    int         last;
    int         idx;
    logic       coll;
    logic [4:0] used [2];
    logic [7:0] rdy;
    #1;
    rdy  = '0;
    ng   = 0;
    last = 0;
    used[0] = '0; used[1] = '0;
    e.rt[0] = '0; e.rt[1] = '0;
    e.data[0] = '0; e.data[1] = '0;
    e.en = '0;
    e.slot = '0;
    if (!interlock) begin
      for (int off = 0; off < 8; off++) begin
        idx = (m_ptr + off) % 8;
        if (tb_valid[idx] && ng < 2) begin
          coll = 1'b0;
          for (int g = 0; g < ng; g++) if (used[g] == tb_rt[idx]) coll = 1'b1;
          if (!coll) begin
            rdy[idx]    = 1'b1;
            used[ng]    = tb_rt[idx];
            e.rt[ng]    = tb_rt[idx];
            e.data[ng]  = tb_data[idx];
            e.en[ng]    = (tb_rt[idx] != 5'd0);
            e.slot[ng]  = 1'b1;
            last        = idx;
            ng++;
          end
        end
      end
      e.ptr      = (ng > 0) ? 3'((last + 1) % 8) : 3'(m_ptr);
      e.conflict = (ng < 2) && ((tb_valid & ~rdy) != 8'h00);
    end else begin
      e.slot     = m_slot;
      e.rt[0]    = m_rt[0];   e.rt[1]   = m_rt[1];
      e.data[0]  = m_data[0]; e.data[1] = m_data[1];
      e.ptr      = 3'(m_ptr);
      e.conflict = 1'b0;
    end
    chk({tag, ".ready"}, 32'(ready), 32'(rdy));
    m_ptr   = int'(e.ptr);
    m_slot  = e.slot;
    m_rt[0] = e.rt[0];     m_rt[1]   = e.rt[1];
    m_data[0] = e.data[0]; m_data[1] = e.data[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmp_out(tag);
    tb_valid = tb_valid & ~rdy;
  endtask

  // Synchronous-looking reset pulse used between directed tests.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_ready"}, 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".rst_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ".rst_ptr"}, 32'(rr_ptr), 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (tb_valid != 8'h00 && guard < 16) begin
      run_cycle(tag);
      guard++;
    end
    chk({tag, ".drained"}, 32'(tb_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] ptr_seq [4];
    rst       = 1'b1;
    interlock = 1'b0;
    tb_valid  = 8'h00;
    tb_rt     = '0;
    tb_data   = '0;
    model_clear();

    // Reset state
    #3;
    chk("reset.wr_en", 32'(wr_en), 32'd0);
    chk("reset.wr_rt", 32'(wr_rt), 32'd0);
    chk("reset.wr_data0", wr_data[0], 32'd0);
    chk("reset.ptr", 32'(rr_ptr), 32'd0);
    chk("reset.conflict", 32'(conflict), 32'd0);
    chk("reset.ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single source
    tb_valid = 8'h01; tb_rt[0] = 5'd3; tb_data[0] = 32'hDEADBEEF;
    run_cycle("single");
    chk("single.data_const", wr_data[0], 32'hDEADBEEF);
    chk("single.ptr_const", 32'(rr_ptr), 32'd1);

    // All eight valid, distinct destinations
    do_reset("all");
    ptr_seq[0] = 3'd2; ptr_seq[1] = 3'd4; ptr_seq[2] = 3'd6; ptr_seq[3] = 3'd0;
    for (int i = 0; i < 8; i++) begin
      tb_rt[i]   = 5'(i + 1);
      tb_data[i] = 32'h1000 + 32'(i);
    end
    tb_valid = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      run_cycle($sformatf("all%0d", c));
      chk($sformatf("all%0d.ptr_const", c), 32'(rr_ptr), 32'(ptr_seq[c]));
      chk($sformatf("all%0d.en_const", c), 32'(wr_en), 32'd3);
    end

    // Collision with no free port
    do_reset("coll");
    tb_rt[0] = 5'd5; tb_rt[1] = 5'd5; tb_rt[2] = 5'd6;
    tb_valid = 8'h07;
    run_cycle("coll0");
    chk("coll0.rt1_const", 32'(wr_rt[1]), 32'd6);
    chk("coll0.stall_const", 32'(conflict), 32'd0);
    run_cycle("coll1");

    // Collision while a port is free
    do_reset("cfree");
    tb_rt[3] = 5'd7; tb_rt[4] = 5'd7;
    tb_valid = 8'h18;
    run_cycle("cfree0");
    chk("cfree0.en_const", 32'(wr_en), 32'd1);
    chk("cfree0.stall_const", 32'(conflict), 32'd1);
    run_cycle("cfree1");

    // Interlock freezes grants and pointer
    do_reset("ilk");
    for (int i = 0; i < 8; i++) tb_rt[i] = 5'(i + 1);
    tb_valid = 8'hFF;
    run_cycle("ilk_pre");
    interlock = 1'b1;
    for (int c = 0; c < 3; c++) run_cycle($sformatf("ilk%0d", c));
    chk("ilk.ptr_const", 32'(rr_ptr), 32'd2);
    interlock = 1'b0;
    drain("ilk_post");

    // rt==0 consumed without a write, then asynchronous reset mid-cycle
    do_reset("rt0");
    tb_rt[0] = 5'd0; tb_data[0] = 32'h0BAD0000;
    tb_rt[1] = 5'd9; tb_data[1] = 32'h12345678;
    tb_valid = 8'h03;
    run_cycle("rt0");
    chk("rt0.en_const", 32'(wr_en), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async.wr_en", 32'(wr_en), 32'd0);
    chk("async.ptr", 32'(rr_ptr), 32'd0);
    tb_valid = 8'hFF;
    #1;
    chk("async.ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    tb_valid = 8'h00;

    // Random traffic with frequent collisions and occasional interlock
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (!tb_valid[i] && ($urandom_range(0, 1) == 1)) begin
          tb_valid[i] = 1'b1;
          tb_rt[i]    = 5'($urandom_range(0, 7));
          tb_data[i]  = $urandom;
        end
      end
      interlock = ($urandom_range(0, 7) == 0);
      run_cycle($sformatf("rnd%0d", c));
    end
    interlock = 1'b0;
    drain("rnd_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
